// File: rtl/grf_wb_stage.sv
// Registered writeback slot for the MIPS pipeline: selects the GRF write data,
// holds it across stalls, drives the GRF write port and W-stage forwarding.
module grf_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_SRC  = 5,
    parameter int SEL_W    = 3,
    parameter int LINK_IDX = 3,
    parameter int LINK_OFS = 8,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic                      in_we,
    input  logic [ADDR_W-1:0]         in_wa,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      grf_we,
    output logic [ADDR_W-1:0]         grf_wa,
    output logic [DATA_W-1:0]         grf_wd,
    output logic                      fwd_valid,
    output logic [ADDR_W-1:0]         fwd_addr,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          retire_cnt
);

    function automatic logic [DATA_W-1:0] link_value(input logic [DATA_W-1:0] pc);
        return pc + DATA_W'(LINK_OFS);
    endfunction

    // ---- p0: source select (combinational, ahead of the slot register) ----
    logic [DATA_W-1:0] data_p0;
    logic              sel_ok_p0;

    always_comb begin
        data_p0   = '0;
        sel_ok_p0 = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_ok_p0 = 1'b1;
                data_p0   = (k == LINK_IDX) ? link_value(in_pc) : in_src[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready = !stall;

    // ---- p1: W slot register ----
    logic              vld_p1;
    logic              we_p1;
    logic [ADDR_W-1:0] wa_p1;
    logic [DATA_W-1:0] data_p1;
    logic              done_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            we_p1      <= 1'b0;
            wa_p1      <= '0;
            data_p1    <= '0;
            done_p1    <= 1'b0;
            sel_err    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (grf_we)
                retire_cnt <= retire_cnt + CNT_W'(1);

            if (flush) begin
                vld_p1  <= 1'b0;
                done_p1 <= 1'b0;
            end else if (stall) begin
                // Held instruction already wrote once; block repeat writes.
                if (vld_p1)
                    done_p1 <= 1'b1;
            end else if (in_valid) begin
                vld_p1  <= 1'b1;
                we_p1   <= in_we && sel_ok_p0;
                wa_p1   <= in_wa;
                data_p1 <= data_p0;
                done_p1 <= 1'b0;
                if (!sel_ok_p0)
                    sel_err <= 1'b1;
            end else begin
                vld_p1  <= 1'b0;
                done_p1 <= 1'b0;
            end
        end
    end

    assign fwd_valid = vld_p1 && we_p1 && (wa_p1 != '0);
    assign fwd_addr  = wa_p1;
    assign fwd_data  = data_p1;
    assign grf_we    = fwd_valid && !done_p1;
    assign grf_wa    = wa_p1;
    assign grf_wd    = data_p1;

endmodule

// File: tb/tb_grf_wb_stage.sv
// Bench for grf_wb_stage: directed scenarios plus random traffic, each cycle
// compared against a per-instruction behavioural model.
module tb_grf_wb_stage;
    localparam int DATA_W   = 32;
    localparam int NUM_SRC  = 5;
    localparam int SEL_W    = 3;
    localparam int LINK_IDX = 3;
    localparam int LINK_OFS = 8;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_SRC*DATA_W-1:0] in_src;
    logic [DATA_W-1:0]         in_pc;
    logic                      in_we;
    logic [ADDR_W-1:0]         in_wa;
    logic                      stall;
    logic                      flush;
    logic                      grf_we;
    logic [ADDR_W-1:0]         grf_wa;
    logic [DATA_W-1:0]         grf_wd;
    logic                      fwd_valid;
    logic [ADDR_W-1:0]         fwd_addr;
    logic [DATA_W-1:0]         fwd_data;
    logic                      sel_err;
    logic [CNT_W-1:0]          retire_cnt;

    grf_wb_stage #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .LINK_IDX(LINK_IDX),
        .LINK_OFS(LINK_OFS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_src(in_src), .in_pc(in_pc), .in_we(in_we),
        .in_wa(in_wa), .stall(stall), .flush(flush), .grf_we(grf_we),
        .grf_wa(grf_wa), .grf_wd(grf_wd), .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .sel_err(sel_err),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: the instruction currently in W and whether it has already retired.
    logic              m_v, m_we, m_ret, m_err;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_cnt;

    function automatic logic [DATA_W-1:0] ref_data(input int sel, input logic [DATA_W-1:0] pc,
                                                   input logic [NUM_SRC*DATA_W-1:0] src);
        if (sel == LINK_IDX) return pc + DATA_W'(LINK_OFS);
        if (sel < NUM_SRC)   return src[sel*DATA_W +: DATA_W];
        return '0;
    endfunction

    function automatic logic exp_fwd();
        return m_v && m_we && (m_wa != 0);
    endfunction

    function automatic logic exp_write();
        return exp_fwd() && !m_ret;
    endfunction

    task automatic model_reset();
        m_v = 0; m_we = 0; m_ret = 0; m_err = 0; m_wa = '0; m_data = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            if (exp_write()) begin
                m_cnt++;
                m_ret = 1;
            end
            if (flush) begin
                m_v = 0;
            end else if (stall) begin
                // held
            end else if (in_valid) begin
                m_v    = 1;
                m_we   = in_we && (int'(in_sel) < NUM_SRC);
                m_wa   = in_wa;
                m_data = ref_data(int'(in_sel), in_pc, in_src);
                m_ret  = 0;
                if (int'(in_sel) >= NUM_SRC) m_err = 1;
            end else begin
                m_v = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_grf_we"}, grf_we, exp_write());
        chk({tag, "_fwd_valid"}, fwd_valid, exp_fwd());
        chk({tag, "_sel_err"}, sel_err, m_err);
        chk({tag, "_cnt"}, retire_cnt, m_cnt);
        chk({tag, "_in_ready"}, in_ready, !stall);
        if (m_v) begin
            chk({tag, "_grf_wa"}, grf_wa, m_wa);
            chk({tag, "_grf_wd"}, grf_wd, m_data);
            chk({tag, "_fwd_addr"}, fwd_addr, m_wa);
            chk({tag, "_fwd_data"}, fwd_data, m_data);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic offer(input int sel, input int wa, input logic we, input logic [DATA_W-1:0] pc);
        for (int k = 0; k < NUM_SRC; k++) in_src[k*DATA_W +: DATA_W] = $urandom;
        in_valid = 1; in_sel = SEL_W'(sel); in_wa = ADDR_W'(wa); in_we = we; in_pc = pc;
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0;
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_grf_we"}, grf_we, 0);
        chk({tag, "_fwd_valid"}, fwd_valid, 0);
        chk({tag, "_grf_wa"}, grf_wa, 0);
        chk({tag, "_grf_wd"}, grf_wd, 0);
        chk({tag, "_sel_err"}, sel_err, 0);
        chk({tag, "_cnt"}, retire_cnt, 0);
    endtask

    initial begin
        reset = 0; in_valid = 0; in_sel = '0; in_src = '0; in_pc = '0;
        in_we = 0; in_wa = '0; stall = 0; flush = 0;
        model_reset();
        repeat (3) @(negedge clk);
        zero_outputs("rst");
        chk("rst_in_ready", in_ready, 1);
        reset = 1;

        // Plain accept from source 0
        offer(0, 8, 1, 32'h0);
        in_src[0 +: DATA_W] = 32'h1234_5678;
        step("t1");
        chk("t1_we", grf_we, 1);
        chk("t1_wa", grf_wa, 8);
        chk("t1_wd", grf_wd, 32'h1234_5678);
        chk("t1_fwd", fwd_valid, 1);
        idle();
        step("t1b");
        chk("t1_cnt", retire_cnt, 1);

        // Link value, including wrap-around
        offer(LINK_IDX, 31, 1, 32'h0000_3000);
        step("t2a");
        chk("t2a_wd", grf_wd, 32'h0000_3008);
        offer(LINK_IDX, 31, 1, 32'hFFFF_FFFC);
        step("t2b");
        chk("t2b_wd", grf_wd, 32'h0000_0004);

        // Single retire across a 4-cycle stall
        offer(1, 9, 1, 32'h0);
        in_src[DATA_W +: DATA_W] = 32'h0000_00AA;
        step("t3");
        chk("t3_we0", grf_we, 1);
        in_valid = 0; stall = 1;
        for (int i = 0; i < 4; i++) begin
            step("t3s");
            chk("t3s_we", grf_we, 0);
            chk("t3s_fwd", fwd_valid, 1);
            chk("t3s_wd", grf_wd, 32'hAA);
        end
        stall = 0;
        step("t3e");
        chk("t3_cnt", retire_cnt, 4);

        // $0 destination and illegal select
        offer(0, 0, 1, 32'h0);
        step("t4a");
        chk("t4a_we", grf_we, 0);
        chk("t4a_fwd", fwd_valid, 0);
        offer(7, 12, 1, 32'h0);
        step("t4b");
        chk("t4b_we", grf_we, 0);
        chk("t4b_err", sel_err, 1);
        idle();
        repeat (10) step("t4i");
        chk("t4_err_sticky", sel_err, 1);
        chk("t4_cnt", retire_cnt, 4);

        // Stall and flush together
        offer(2, 5, 1, 32'h0);
        step("t5a");
        stall = 1; flush = 1; offer(0, 6, 1, 32'h0);
        #1;
        chk("t5_ready", in_ready, 0);
        step("t5b");
        chk("t5_we", grf_we, 0);
        chk("t5_fwd", fwd_valid, 0);
        idle();
        step("t5c");

        // Asynchronous reset in the middle of a stall
        offer(4, 10, 1, 32'h0);
        step("t6a");
        in_valid = 0; stall = 1;
        step("t6b");
        #2 reset = 0;
        #1;
        zero_outputs("t6_async");
        step("t6c");
        reset = 1;
        repeat (3) begin
            step("t6s");
            chk("t6s_we", grf_we, 0);
        end
        stall = 0;
        repeat (2) begin
            step("t6i");
            chk("t6i_we", grf_we, 0);
        end

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NUM_SRC; k++) in_src[k*DATA_W +: DATA_W] = $urandom;
            in_valid = ($urandom_range(0, 9) < 7);
            in_sel   = SEL_W'($urandom_range(0, 7));
            in_wa    = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
            in_we    = ($urandom_range(0, 4) != 0);
            in_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/grf_wb_stage.md
# grf_wb_stage

Parametrised writeback stage for the pipelined MIPS core. It replaces the purely combinational GRF write-data selector with a registered W-stage slot. The slot selects one of `NUM_SRC` result buses plus a PC-link value and captures it under a valid/ready handshake with stall and flush. It drives the GRF write port and the W-stage forwarding bus. It also flags illegal selects and counts retired register writes.

## Interface
Parameters:
- `DATA_W`, 32, datapath width.
- `NUM_SRC`, 5, number of selectable sources; select code `k` picks source `k`.
- `SEL_W`, 3, select width; must satisfy `2**SEL_W >= NUM_SRC`.
- `LINK_IDX`, 3, select code whose value is `in_pc + LINK_OFS`; the bus slot at this index is ignored.
- `LINK_OFS`, 8, link offset added to PC.
- `ADDR_W`, 5, GRF address width.
- `CNT_W`, 32, retire counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `in_valid` in 1: M stage presents an instruction.
- `in_ready` out 1: slot can accept; equals `!stall`.
- `in_sel` in SEL_W: write-data source select.
- `in_src` in NUM_SRC*DATA_W: flattened source buses; source `k` occupies bits `[k*DATA_W +: DATA_W]`.
- `in_pc` in DATA_W: instruction PC.
- `in_we` in 1: instruction writes the GRF.
- `in_wa` in ADDR_W: destination register.
- `stall` in 1: hold the W slot; no accept.
- `flush` in 1: discard the W slot content (exception/eret).
- `grf_we` out 1, `grf_wa` out ADDR_W, `grf_wd` out DATA_W: GRF write port.
- `fwd_valid` out 1, `fwd_addr` out ADDR_W, `fwd_data` out DATA_W: W-stage forwarding.
- `sel_err` out 1: sticky illegal-select flag.
- `retire_cnt` out CNT_W: count of committed GRF writes.

## Operation
- Source mux is evaluated before the register: `LINK_IDX` gives `in_pc + LINK_OFS` (mod 2^DATA_W). Other codes `< NUM_SRC` give the bus slot. Codes `>= NUM_SRC` give data 0.
- Accept occurs when `in_valid && in_ready && !flush` at a rising edge. The slot then loads `v=1`, `we`, `wa`, `data`, and `done=0`.
- Illegal select on accept: the slot loads with `we=0`, and `sel_err` sets on that edge. `sel_err` stays set until reset.
- No accept and no stall, no flush: the slot loads `v=0` (bubble).
- `stall` high, no flush: the slot holds all fields. `done` sets to 1 at the edge after the first write cycle.
- `flush` high: the slot loads `v=0` regardless of `stall` or `in_valid`. Flush has highest priority below reset.
- `grf_we = v && we && !done && (wa != 0)`. `grf_wa = wa`, `grf_wd = data`.
- A write to `$0` is suppressed and not counted.
- `fwd_valid = v && we && (wa != 0)`. It is asserted for every cycle the slot holds the value, including stalled cycles.
- `fwd_addr = wa`, `fwd_data = data`.
- `retire_cnt` increments by 1 on every edge where `grf_we` is 1. It wraps modulo 2^CNT_W.
- The single retire per instruction holds regardless of stall length.

## Timing
- Reset values: `v=0`, `we=0`, `wa=0`, `data=0`, `done=0`, `sel_err=0`, `retire_cnt=0`.
- Consequently, after reset `grf_we=0` and `fwd_valid=0`. `in_ready` is 1 unless `stall` is high.
- Latency is 1 cycle: data accepted at edge N appears on `grf_*` and `fwd_*` during cycle N to N+1.
- All outputs except `in_ready` are registered or derived only from the registered slot. `in_ready` is combinational from `stall`.
- Reset asserted mid-stall: the slot clears immediately and asynchronously. No write is issued after reset releases.
- `stall` and `flush` together: flush wins, and the slot is empty next cycle.
- `in_valid` high while `stall` high: the instruction is not taken. The upstream stage must hold it.

## Test plan
- Reset, then accept `sel=0`, `src0=0x1234_5678`, `wa=8`, `we=1`. Required: next cycle `grf_we=1`, `grf_wa=8`, `grf_wd=0x12345678`, `fwd_valid=1`, and `retire_cnt=1` after that edge.
- Accept `sel=LINK_IDX`, `in_pc=0x0000_3000`, `wa=31`. Required: `grf_wd=0x00003008`. Repeat with `in_pc=0xFFFF_FFFC`; required: `grf_wd=0x00000004`.
- Accept `wa=9` data `0xAA`, then hold `stall=1` for 4 cycles. Required: `grf_we=1` only in the first cycle, `fwd_valid=1` for all 5 cycles, `retire_cnt` +1 only.
- Accept `wa=0`, `we=1`. Required: `grf_we=0`, `fwd_valid=0`, count unchanged. Next, accept `sel=7`. Required: `grf_we=0`, `sel_err=1`, still 1 after 10 idle cycles.
- Raise `stall=1` and `flush=1` together with `in_valid=1`. Required: slot empty next cycle (`grf_we=0`, `fwd_valid=0`) and `in_ready=0` during the stall.
- Mid-stall, pull `reset` low between clock edges. Required: all outputs zero immediately. After release, no write occurs until a new accept.
